// File: rtl/fp_pkg.sv
// fp_pkg: shared widths and stage payload types for the fp adder normalization path
//   EXP_W/SIG_W/MANT_W : exponent, significand and raw-sum widths
//   norm_in_t          : S1 payload (biased exponent + raw 27-bit sum)
//   norm_s2_t          : S2 payload (S1 payload + leading-zero count + low-zero flag)
//   norm_out_t         : S3 payload (normalized exponent/significand + flags)
package fp_pkg;
    localparam int EXP_W = 8;
    localparam int SIG_W = 24;
    localparam int MANT_W = 27;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    typedef struct packed {
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } norm_in_t;
    typedef struct packed {
        norm_in_t   d;
        logic [4:0] lz;
        logic       low_zero;
    } norm_s2_t;
    typedef struct packed {
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] mant;
        logic             zero;
        logic             ovf;
        logic             unf;
    } norm_out_t;
endpackage

// File: rtl/fp_normalizer_if.sv
// fp_normalizer_if: valid/ready handshake and data bus of the normalization stage
//   in_*  : raw sum beat from the significand adder (slave consumes)
//   out_* : normalized result with zero/overflow/underflow flags (slave produces)
interface fp_normalizer_if;
    import fp_pkg::*;
    logic              in_valid;
    logic              in_ready;
    logic [EXP_W-1:0]  in_exp;
    logic [MANT_W-1:0] in_mant;
    logic              out_valid;
    logic              out_ready;
    logic [EXP_W-1:0]  out_exp;
    logic [SIG_W-1:0]  out_mant;
    logic              out_zero;
    logic              out_ovf;
    logic              out_unf;
    modport slave (
        input  in_valid, in_exp, in_mant, out_ready,
        output in_ready, out_valid, out_exp, out_mant, out_zero, out_ovf, out_unf
    );
    modport master (
        output in_valid, in_exp, in_mant, out_ready,
        input  in_ready, out_valid, out_exp, out_mant, out_zero, out_ovf, out_unf
    );
endinterface

// File: rtl/fp_lzc.sv
// fp_lzc: combinational 25-bit leading-zero counter
//   d        : input vector, MSB first
//   cnt      : number of leading zeros (25 when d is zero)
//   all_zero : d has no set bit
module fp_lzc (
    input  logic [24:0] d,
    output logic [4:0]  cnt,
    output logic        all_zero
);
    always_comb begin
        cnt = 5'd25;
        for (int i = 0; i < 25; i++)
            if (d[i]) cnt = 5'(24 - i);
    end
    assign all_zero = ~|d;
endmodule

// File: rtl/fp_normalizer.sv
// fp_normalizer: 3-stage post-add normalizer (carry right-shift / LZC left-shift, exp adjust, flags)
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fp_normalizer_if.slave (in_valid/in_ready/in_exp/in_mant, out_valid/out_ready/out_exp/out_mant/out_zero/out_ovf/out_unf)
//   FP_NORM_ROUND_EN : when defined, S3 rounds to nearest even; otherwise it truncates
module fp_normalizer
    import fp_pkg::*;
(
    input logic             clk,
    input logic             rst,
    fp_normalizer_if.slave  bus
);
    logic      en;
    logic      s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s3_valid_q, s3_valid_d;
    norm_in_t  s1_q, s1_d;
    norm_s2_t  s2_q, s2_d;
    norm_out_t s3_q, s3_d, res;
    logic [4:0] lz;
    logic       lz_zero;
    logic [8:0]  exp9;
    logic [23:0] sig;
    logic [24:0] shl;
    logic        rnd, stk, zero, unf, ovf, grew;
    // One global stall: every stage moves only when the output slot is free.
    assign en = !s3_valid_q || bus.out_ready;
    fp_lzc u_lzc (
        .d        (s1_q.mant[25:1]),
        .cnt      (lz),
        .all_zero (lz_zero)
    );
    always_comb begin
        s1_valid_d = en ? bus.in_valid : s1_valid_q;
        s1_d       = en ? {bus.in_exp, bus.in_mant} : s1_q;
        s2_valid_d = en ? s1_valid_q : s2_valid_q;
        s2_d       = en ? {s1_q, lz, lz_zero} : s2_q;
        s3_valid_d = en ? s2_valid_q : s3_valid_q;
        s3_d       = en ? res : s3_q;
    end
    always_comb begin
        shl  = s2_q.d.mant[25:1] << s2_q.lz;
        exp9 = {1'b0, s2_q.d.exp};
        sig  = s2_q.d.mant[25:2];
        rnd  = s2_q.d.mant[1];
        stk  = s2_q.d.mant[0];
        zero = 1'b0;
        unf  = 1'b0;
        grew = 1'b0;
        if (s2_q.d.mant[26]) begin
            sig  = s2_q.d.mant[26:3];
            rnd  = s2_q.d.mant[2];
            stk  = |s2_q.d.mant[1:0];
            exp9 = exp9 + 9'd1;
            grew = 1'b1;
        end else if (!s2_q.d.mant[25]) begin
            if (s2_q.low_zero) begin
                zero = 1'b1;
            end else if ({4'b0, s2_q.lz} >= exp9) begin
                zero = 1'b1;
                unf  = 1'b1;
            end else begin
                sig  = shl[24:1];
                rnd  = shl[0];
                exp9 = exp9 - {4'b0, s2_q.lz};
            end
        end
`ifdef FP_NORM_ROUND_EN
        // Round-to-nearest-even; a carry out of the significand renormalizes to 1.0 with exp+1.
        if (!zero && rnd && (stk || sig[0])) begin
            sig  = sig + 24'd1;
            if (sig == 24'd0) begin
                sig  = 24'h800000;
                exp9 = exp9 + 9'd1;
                grew = 1'b1;
            end
        end
`endif
        // Only a carry or round carry can push the exponent into the reserved code.
        ovf      = !zero && grew && (exp9 >= {1'b0, EXP_MAX});
        res.exp  = zero ? '0 : (ovf ? EXP_MAX : exp9[7:0]);
        res.mant = (zero || ovf) ? '0 : sig;
        res.zero = zero;
        res.ovf  = ovf;
        res.unf  = unf;
    end
`ifndef FP_NORM_ROUND_EN
    logic unused_rs;
    assign unused_rs = rnd ^ stk;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
            s3_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s3_valid_q <= s3_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
        end
    end
    assign bus.in_ready  = en;
    assign bus.out_valid = s3_valid_q;
    assign bus.out_exp   = s3_q.exp;
    assign bus.out_mant  = s3_q.mant;
    assign bus.out_zero  = s3_q.zero;
    assign bus.out_ovf   = s3_q.ovf;
    assign bus.out_unf   = s3_q.unf;
endmodule

// File: tb/tb_fp_normalizer.sv
// tb_fp_normalizer: directed self-checking bench for fp_normalizer (honours FP_NORM_ROUND_EN)
module tb_fp_normalizer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    fp_normalizer_if bus();
    fp_normalizer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask
    function automatic logic [63:0] pk(input logic [7:0] e, input logic [23:0] m,
                                       input logic z, input logic o, input logic u);
        return {29'b0, e, m, z, o, u};
    endfunction
    function automatic logic [63:0] obs();
        return pk(bus.out_exp, bus.out_mant, bus.out_zero, bus.out_ovf, bus.out_unf);
    endfunction
    // One beat with out_ready high; out_valid must rise on the second edge after the accepting edge.
    task automatic run_vec(input string tag, input logic [7:0] e, input logic [26:0] m,
                           input logic [63:0] want);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_exp   = e;
        bus.in_mant  = m;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 10) begin
            @(posedge clk);
            #1 n++;
        end
        check({tag, "_lat"}, 64'(n), 64'd2);
        check(tag, obs(), want);
    endtask
    task automatic push(input logic [7:0] e, input logic [26:0] m);
        @(negedge clk);
        check("stall_in_ready_open", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_exp   = e;
        bus.in_mant  = m;
    endtask
    logic [63:0] exp_a, exp_b, exp_c;
    initial begin
        bus.in_valid  = 1'b0;
        bus.in_exp    = '0;
        bus.in_mant   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_outputs", obs(), 64'd0);
        run_vec("carry",        8'd130, 27'h4000000, pk(8'd131, 24'h800000, 0, 0, 0));
        run_vec("lz5",          8'd130, 27'h0100000, pk(8'd125, 24'h800000, 0, 0, 0));
        run_vec("unf",          8'd3,   27'h0100000, pk(8'd0,   24'h000000, 1, 0, 1));
        run_vec("ovf",          8'd254, 27'h4000000, pk(8'd255, 24'h000000, 0, 1, 0));
        run_vec("sticky_only",  8'd50,  27'h0000001, pk(8'd0,   24'h000000, 1, 0, 0));
        run_vec("lz_eq_exp",    8'd5,   27'h0100000, pk(8'd0,   24'h000000, 1, 0, 1));
        run_vec("lz_exp_m1",    8'd6,   27'h0100000, pk(8'd1,   24'h800000, 0, 0, 0));
        run_vec("round_only",   8'd30,  27'h0000002, pk(8'd6,   24'h800000, 0, 0, 0));
        run_vec("carry_sticky", 8'd10,  27'h7000001, pk(8'd11,  24'hE00000, 0, 0, 0));
        run_vec("lz1_rbit_in",  8'd40,  27'h1000003, pk(8'd39,  24'h800001, 0, 0, 0));
`ifdef FP_NORM_ROUND_EN
        run_vec("tie_even",     8'd100, 27'h2000006, pk(8'd100, 24'h800002, 0, 0, 0));
        run_vec("round_cout",   8'd100, 27'h3FFFFFE, pk(8'd101, 24'h800000, 0, 0, 0));
        run_vec("round_ovf",    8'd254, 27'h3FFFFFE, pk(8'd255, 24'h000000, 0, 1, 0));
        run_vec("carry_round",  8'd20,  27'h400000C, pk(8'd21,  24'h800002, 0, 0, 0));
        exp_c = pk(8'd100, 24'h800002, 0, 0, 0);
`else
        run_vec("tie_even",     8'd100, 27'h2000006, pk(8'd100, 24'h800001, 0, 0, 0));
        run_vec("round_cout",   8'd100, 27'h3FFFFFE, pk(8'd100, 24'hFFFFFF, 0, 0, 0));
        run_vec("round_ovf",    8'd254, 27'h3FFFFFE, pk(8'd254, 24'hFFFFFF, 0, 0, 0));
        run_vec("carry_round",  8'd20,  27'h400000C, pk(8'd21,  24'h800001, 0, 0, 0));
        exp_c = pk(8'd100, 24'h800001, 0, 0, 0);
`endif
        exp_a = pk(8'd131, 24'h800000, 0, 0, 0);
        exp_b = pk(8'd125, 24'h800000, 0, 0, 0);
        // Back-to-back beats into a stalled output: three fill the pipe, then in_ready closes.
        repeat (2) @(negedge clk);
        bus.out_ready = 1'b0;
        push(8'd130, 27'h4000000);
        push(8'd130, 27'h0100000);
        push(8'd100, 27'h2000006);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            check("stall_valid", 64'(bus.out_valid), 64'd1);
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
            check("stall_hold_a", obs(), exp_a);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("drain_b_valid", 64'(bus.out_valid), 64'd1);
        check("drain_b", obs(), exp_b);
        @(negedge clk);
        check("drain_c_valid", 64'(bus.out_valid), 64'd1);
        check("drain_c", obs(), exp_c);
        @(negedge clk);
        check("drain_empty", 64'(bus.out_valid), 64'd0);
        // Asynchronous reset while a result is held and more beats are in flight.
        bus.out_ready = 1'b0;
        push(8'd130, 27'h4000000);
        push(8'd130, 27'h0100000);
        push(8'd6,   27'h0100000);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        #2 rst = 1'b1;
        #1 check("async_rst_valid", 64'(bus.out_valid), 64'd0);
        check("async_rst_out", obs(), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_silent", 64'(bus.out_valid), 64'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
